wb_arbiter: RTL and testbench

Writeback arbiter and sequencer for the integer register file's single write port. It accepts results from three writeback sources: load/store (mem), execute/CSR (ex) and multiply/divide (md). Each source gets a one-entry holding buffer. Each cycle the arbiter grants at most one buffered result to the regfile `wreg`/`wdata`/`wen` port. Every accepted result to a nonzero register is eventually written exactly once, which clears the register's reservation bit.

---
 rtl/wb_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter for the regfile write port (mem/ex/md sources)
// Define WB_ARB_RR_EN for round-robin arbitration; default is fixed priority mem > ex > md.
module wb_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [4:0]      ex_rd,
   input  logic [XLEN-1:0] ex_data,
   input  logic            md_valid,
   output logic            md_ready,
   input  logic [4:0]      md_rd,
   input  logic [XLEN-1:0] md_data,
   output logic [4:0]      wreg,
   output logic [XLEN-1:0] wdata,
   output logic            wen,
   output logic            idle
);

   localparam logic [1:0] SRC_MEM = 2'd0;
   localparam logic [1:0] SRC_EX  = 2'd1;
   localparam logic [1:0] SRC_MD  = 2'd2;

   logic            full_mem, full_ex, full_md;
   logic [4:0]      rd_mem, rd_ex, rd_md;
   logic [XLEN-1:0] data_mem, data_ex, data_md;

   // grant is bit-per-source: [0]=mem, [1]=ex, [2]=md
   logic [2:0] grant;
   logic [2:0] grant_q;
   logic       load_mem, load_ex, load_md;

`ifdef WB_ARB_RR_EN
   logic [1:0] last_src;

   // Search starts at the source after the last one granted.
   always_comb begin
      grant = 3'b000;
      case (last_src)
         SRC_MEM: begin
            if (full_ex)       grant = 3'b010;
            else if (full_md)  grant = 3'b100;
            else if (full_mem) grant = 3'b001;
         end
         SRC_EX: begin
            if (full_md)       grant = 3'b100;
            else if (full_mem) grant = 3'b001;
            else if (full_ex)  grant = 3'b010;
         end
         default: begin
            if (full_mem)      grant = 3'b001;
            else if (full_ex)  grant = 3'b010;
            else if (full_md)  grant = 3'b100;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_src <= SRC_MD;
      end else if (wen) begin
         if (grant[0])      last_src <= SRC_MEM;
         else if (grant[1]) last_src <= SRC_EX;
         else               last_src <= SRC_MD;
      end
   end
`else
   always_comb begin
      grant = 3'b000;
      if (full_mem)      grant = 3'b001;
      else if (full_ex)  grant = 3'b010;
      else if (full_md)  grant = 3'b100;
   end
`endif

   // Outputs are forced quiet while reset is held, even before the buffers clear.
   assign grant_q   = grant & {3{reset_n}};
   assign wen       = |grant_q;
   assign idle      = ~reset_n | ~(full_mem | full_ex | full_md);

   assign mem_ready = reset_n & (~full_mem | grant[0]);
   assign ex_ready  = reset_n & (~full_ex  | grant[1]);
   assign md_ready  = reset_n & (~full_md  | grant[2]);

   assign wreg  = ({5{grant_q[0]}} & rd_mem)
                | ({5{grant_q[1]}} & rd_ex)
                | ({5{grant_q[2]}} & rd_md);
   assign wdata = ({XLEN{grant_q[0]}} & data_mem)
                | ({XLEN{grant_q[1]}} & data_ex)
                | ({XLEN{grant_q[2]}} & data_md);

   // x0 results are accepted but never loaded.
   assign load_mem = mem_valid & mem_ready & (mem_rd != 5'd0);
   assign load_ex  = ex_valid  & ex_ready  & (ex_rd  != 5'd0);
   assign load_md  = md_valid  & md_ready  & (md_rd  != 5'd0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         full_mem <= 1'b0;
         rd_mem   <= 5'd0;
         data_mem <= '0;
      end else if (load_mem) begin
         full_mem <= 1'b1;
         rd_mem   <= mem_rd;
         data_mem <= mem_data;
      end else if (grant[0]) begin
         full_mem <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         full_ex <= 1'b0;
         rd_ex   <= 5'd0;
         data_ex <= '0;
      end else if (load_ex) begin
         full_ex <= 1'b1;
         rd_ex   <= ex_rd;
         data_ex <= ex_data;
      end else if (grant[1]) begin
         full_ex <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         full_md <= 1'b0;
         rd_md   <= 5'd0;
         data_md <= '0;
      end else if (load_md) begin
         full_md <= 1'b1;
         rd_md   <= md_rd;
         data_md <= md_data;
      end else if (grant[2]) begin
         full_md <= 1'b0;
      end
   end

`ifndef SYNTHESIS
   // Decode must never let two buffered results target the same register.
   always @(posedge clk) begin
      if (reset_n && ((full_mem && full_ex && rd_mem == rd_ex) ||
                      (full_mem && full_md && rd_mem == rd_md) ||
                      (full_ex  && full_md && rd_ex  == rd_md)))
         $display("wb_arbiter error: two full buffers hold the same rd");
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter (directed scenarios plus randomized model check)
module tb_wb_arbiter;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            mem_valid, ex_valid, md_valid;
   logic            mem_ready, ex_ready, md_ready;
   logic [4:0]      mem_rd, ex_rd, md_rd;
   logic [XLEN-1:0] mem_data, ex_data, md_data;
   logic [4:0]      wreg;
   logic [XLEN-1:0] wdata;
   logic            wen;
   logic            idle;

   int checks = 0;
   int failures = 0;

   // Reference model: one slot per source (0=mem, 1=ex, 2=md) and the last granted index.
   bit              m_full [3];
   logic [4:0]      m_rd   [3];
   logic [XLEN-1:0] m_data [3];
   int              m_last;

   always #5 clk = ~clk;

   wb_arbiter #(.XLEN(XLEN)) dut (
      .clk(clk), .reset_n(reset_n),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
      .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
      .wreg(wreg), .wdata(wdata), .wen(wen), .idle(idle)
   );

   function automatic int model_grant();
`ifdef WB_ARB_RR_EN
      for (int k = 1; k <= 3; k++)
         if (m_full[(m_last + k) % 3]) return (m_last + k) % 3;
`else
      for (int s = 0; s < 3; s++)
         if (m_full[s]) return s;
`endif
      return -1;
   endfunction

   task automatic clear_inputs();
      mem_valid = 0; mem_rd = 0; mem_data = 0;
      ex_valid  = 0; ex_rd  = 0; ex_data  = 0;
      md_valid  = 0; md_rd  = 0; md_data  = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
      for (int s = 0; s < 3; s++) m_full[s] = 0;
      m_last = 2;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n = 0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({mem_ready, ex_ready, md_ready} !== 3'b000) begin
         failures++; $display("FAIL reset_ready: got %b expected 000", {mem_ready, ex_ready, md_ready});
      end
      checks++;
      if ({wen, wreg, wdata, idle} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
         failures++; $display("FAIL reset_outputs: wen=%b wreg=%0d wdata=%h idle=%b expected 0 0 0 1", wen, wreg, wdata, idle);
      end
      reset_n = 1;
      #1;
      checks++;
      if ({mem_ready, ex_ready, md_ready, idle, wen} !== 5'b11110) begin
         failures++; $display("FAIL post_reset: ready=%b idle=%b wen=%b expected 111 1 0", {mem_ready, ex_ready, md_ready}, idle, wen);
      end
      for (int s = 0; s < 3; s++) m_full[s] = 0;
      m_last = 2;
   endtask

   task automatic test_single_write();
      do_reset();
      ex_valid = 1; ex_rd = 5; ex_data = 32'h1234_5678;
      #1;
      checks++;
      if (ex_ready !== 1'b1) begin
         failures++; $display("FAIL single_ready: got %b expected 1", ex_ready);
      end
      @(negedge clk);
      clear_inputs();
      checks++;
      if ({wen, wreg, wdata} !== {1'b1, 5'd5, 32'h1234_5678}) begin
         failures++; $display("FAIL single_write: wen=%b wreg=%0d wdata=%h expected 1 5 12345678", wen, wreg, wdata);
      end
      @(negedge clk);
      checks++;
      if ({wen, idle} !== 2'b01) begin
         failures++; $display("FAIL single_after: wen=%b idle=%b expected 0 1", wen, idle);
      end
   endtask

   task automatic test_x0_drop();
      do_reset();
      mem_valid = 1; mem_rd = 0; mem_data = 32'hFFFF_FFFF;
      #1;
      checks++;
      if (mem_ready !== 1'b1) begin
         failures++; $display("FAIL x0_ready: got %b expected 1", mem_ready);
      end
      @(negedge clk);
      clear_inputs();
      checks++;
      if ({wen, wreg, wdata, idle} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
         failures++; $display("FAIL x0_drop: wen=%b wreg=%0d wdata=%h idle=%b expected 0 0 0 1", wen, wreg, wdata, idle);
      end
   endtask

   task automatic test_contention();
      logic [4:0]      exp_rd   [3];
      logic [XLEN-1:0] exp_data [3];
      exp_rd   = '{5'd1, 5'd2, 5'd3};
      exp_data = '{32'h11, 32'h22, 32'h33};
      do_reset();
      mem_valid = 1; mem_rd = 1; mem_data = 32'h11;
      ex_valid  = 1; ex_rd  = 2; ex_data  = 32'h22;
      md_valid  = 1; md_rd  = 3; md_data  = 32'h33;
      @(negedge clk);
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({wen, wreg, wdata} !== {1'b1, exp_rd[i], exp_data[i]}) begin
            failures++; $display("FAIL contention_%0d: wen=%b wreg=%0d wdata=%h expected 1 %0d %h", i, wen, wreg, wdata, exp_rd[i], exp_data[i]);
         end
         @(negedge clk);
      end
      checks++;
      if ({wen, idle} !== 2'b01) begin
         failures++; $display("FAIL contention_drain: wen=%b idle=%b expected 0 1", wen, idle);
      end
   endtask

   task automatic test_mem_md_pressure();
      logic [4:0] exp;
      do_reset();
      mem_valid = 1; mem_rd = 1; mem_data = 32'hAAAA;
      md_valid  = 1; md_rd  = 3; md_data  = 32'hDDDD;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
`ifdef WB_ARB_RR_EN
         exp = (i % 2 == 0) ? 5'd1 : 5'd3;
`else
         exp = 5'd1;
`endif
         checks++;
         if ({wen, wreg} !== {1'b1, exp}) begin
            failures++; $display("FAIL pressure_%0d: wen=%b wreg=%0d expected 1 %0d", i, wen, wreg, exp);
         end
         @(negedge clk);
      end
      clear_inputs();
      for (int i = 0; i < 4; i++) @(negedge clk);
      checks++;
      if (idle !== 1'b1) begin
         failures++; $display("FAIL pressure_drain: idle=%b expected 1", idle);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ex_valid = 1; ex_rd = 5'(4 + i); ex_data = 32'h100 + 32'(i);
         #1;
         checks++;
         if (ex_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, ex_ready);
         end
         if (i > 0) begin
            checks++;
            if ({wen, wreg, wdata} !== {1'b1, 5'(3 + i), 32'h100 + 32'(i - 1)}) begin
               failures++; $display("FAIL b2b_write_%0d: wen=%b wreg=%0d wdata=%h expected 1 %0d", i, wen, wreg, wdata, 3 + i);
            end
         end
         @(negedge clk);
      end
      clear_inputs();
      checks++;
      if ({wen, wreg, wdata} !== {1'b1, 5'd7, 32'h103}) begin
         failures++; $display("FAIL b2b_last: wen=%b wreg=%0d wdata=%h expected 1 7 103", wen, wreg, wdata);
      end
      @(negedge clk);
      checks++;
      if ({wen, idle} !== 2'b01) begin
         failures++; $display("FAIL b2b_drain: wen=%b idle=%b expected 0 1", wen, idle);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem_valid = 1; mem_rd = 8;  mem_data = 32'h88;
      ex_valid  = 1; ex_rd  = 9;  ex_data  = 32'h99;
      md_valid  = 1; md_rd  = 10; md_data  = 32'hAA;
      @(negedge clk);
      clear_inputs();
      reset_n = 0;
      #1;
      checks++;
      if ({wen, wreg, wdata, mem_ready, ex_ready, md_ready, idle} !== {1'b0, 5'd0, 32'd0, 3'b000, 1'b1}) begin
         failures++; $display("FAIL reset_mid_during: wen=%b wreg=%0d ready=%b idle=%b expected 0 0 000 1", wen, wreg, {mem_ready, ex_ready, md_ready}, idle);
      end
      @(negedge clk);
      reset_n = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({wen, idle} !== 2'b01) begin
            failures++; $display("FAIL reset_mid_after_%0d: wen=%b idle=%b expected 0 1", i, wen, idle);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      bit              v [3];
      logic [4:0]      rd [3];
      logic [XLEN-1:0] d [3];
      bit              rdy [3];
      int              g;
      int              accepted = 0;
      int              written = 0;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int s = 0; s < 3; s++) begin
            v[s] = (cyc < 2990) && ($urandom_range(0, 99) < 55);
            d[s] = $urandom;
            // Disjoint register ranges keep concurrently buffered rds distinct.
            if ($urandom_range(0, 7) == 0) rd[s] = 5'd0;
            else rd[s] = 5'(s * 10 + 1 + $urandom_range(0, 9));
         end
         mem_valid = v[0]; mem_rd = rd[0]; mem_data = d[0];
         ex_valid  = v[1]; ex_rd  = rd[1]; ex_data  = d[1];
         md_valid  = v[2]; md_rd  = rd[2]; md_data  = d[2];
         #1;
         g = model_grant();
         for (int s = 0; s < 3; s++) rdy[s] = !m_full[s] || (g == s);
         checks++;
         if (g < 0) begin
            if ({wen, wreg, wdata} !== {1'b0, 5'd0, 32'd0}) begin
               failures++; $display("FAIL rand_write cyc %0d: wen=%b wreg=%0d wdata=%h expected no write", cyc, wen, wreg, wdata);
            end
         end else if ({wen, wreg, wdata} !== {1'b1, m_rd[g], m_data[g]}) begin
            failures++; $display("FAIL rand_write cyc %0d: wen=%b wreg=%0d wdata=%h expected 1 %0d %h", cyc, wen, wreg, wdata, m_rd[g], m_data[g]);
         end
         checks++;
         if ({mem_ready, ex_ready, md_ready} !== {rdy[0], rdy[1], rdy[2]}) begin
            failures++; $display("FAIL rand_ready cyc %0d: got %b expected %b", cyc, {mem_ready, ex_ready, md_ready}, {rdy[0], rdy[1], rdy[2]});
         end
         checks++;
         if (idle !== !(m_full[0] || m_full[1] || m_full[2])) begin
            failures++; $display("FAIL rand_idle cyc %0d: got %b", cyc, idle);
         end
         if (wen) written++;
         for (int s = 0; s < 3; s++) begin
            if (v[s] && rdy[s] && rd[s] != 0) begin
               m_full[s] = 1; m_rd[s] = rd[s]; m_data[s] = d[s];
               accepted++;
            end else if (g == s) begin
               m_full[s] = 0;
            end
         end
         if (g >= 0) m_last = g;
         @(negedge clk);
      end
      checks++;
      if (written !== accepted) begin
         failures++; $display("FAIL rand_scoreboard: writes=%0d expected %0d", written, accepted);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_x0_drop();
      test_contention();
      test_mem_md_pressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
